// File: rtl/compr42_pkg.sv
// Shared types and helpers for the compr42_acc_pipe carry-save accumulator.
// `COMPR42_W sets the field width of csa_t (default 16).
`ifndef COMPR42_W
`define COMPR42_W 16
`endif

package compr42_pkg;

   typedef enum logic [0:0] {IDLE, ACC} state_e;

   localparam int unsigned DefMaxBeats = 8;

   // Beat counter must be able to hold MAX_BEATS itself.
   function automatic int unsigned cnt_width(input int unsigned max_beats);
      return $clog2(max_beats + 1);
   endfunction

   localparam int unsigned CW = cnt_width(DefMaxBeats);

   typedef struct packed {
      logic [`COMPR42_W-1:0] sum;
      logic [`COMPR42_W-1:0] carry;
   } csa_t;

endpackage

// File: rtl/compr42_row.sv
// Combinational row of 1-bit 4:2 compressor cells reducing four vectors to (sum, carry).
// Each cell is two chained full adders; cout does not depend on cin, so there is no ripple.
module compr42_row #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] x0_i,
   input  logic [WIDTH-1:0] x1_i,
   input  logic [WIDTH-1:0] x2_i,
   input  logic [WIDTH-1:0] x3_i,
   output logic [WIDTH-1:0] s_o,
   output logic [WIDTH-1:0] c_o
);

   logic [WIDTH-1:0] cin;

   assign cin[0] = 1'b0;
   assign c_o[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic s_a;
      assign s_a    = x0_i[i] ^ x1_i[i] ^ x2_i[i];
      assign s_o[i] = s_a ^ x3_i[i] ^ cin[i];
      // The top cell's cout and carry both have weight 2^WIDTH and are dropped.
      if (i < WIDTH - 1) begin : g_carry
         assign cin[i+1] = (x0_i[i] & x1_i[i]) | (x0_i[i] & x2_i[i]) | (x1_i[i] & x2_i[i]);
         assign c_o[i+1] = (s_a & x3_i[i]) | (s_a & cin[i]) | (x3_i[i] & cin[i]);
      end
   end

endmodule

// File: rtl/compr42_acc_pipe.sv
// Registered 4:2 carry-save compressor with multi-beat accumulation and valid/ready handshake.
// Define COMPR42_ACC_PIPE_CPA_EN to also register the carry-propagated result on out_res.
module compr42_acc_pipe
   import compr42_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned MAX_BEATS = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_first,
   input  logic                              in_last,
   input  logic [WIDTH-1:0]                  in_a0,
   input  logic [WIDTH-1:0]                  in_a1,
   input  logic [WIDTH-1:0]                  in_a2,
   input  logic [WIDTH-1:0]                  in_a3,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [WIDTH-1:0]                  out_sum,
   output logic [WIDTH-1:0]                  out_carry,
   output logic [WIDTH-1:0]                  out_res,
   output logic [cnt_width(MAX_BEATS)-1:0]   beat_cnt,
   output logic                              err
);

   localparam int unsigned CntW = cnt_width(MAX_BEATS);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  acc_s_q, acc_s_d, acc_c_q, acc_c_d;
   logic [WIDTH-1:0]  out_sum_q, out_sum_d, out_carry_q, out_carry_d;
   logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic              out_valid_q, out_valid_d;
   logic              err_q, err_d;

   logic              fire, acc_zero, force_last, fire_last;
   logic [WIDTH-1:0]  acc_s_in, acc_c_in, s1, c1, s2, c2;

   assign in_ready = !out_valid_q | out_ready;
   assign fire     = in_valid & in_ready;
   assign acc_zero = in_first | (state_q == IDLE);
   assign acc_s_in = acc_zero ? '0 : acc_s_q;
   assign acc_c_in = acc_zero ? '0 : acc_c_q;

   compr42_row #(.WIDTH(WIDTH)) u_lvl1 (
      .x0_i (in_a0),
      .x1_i (in_a1),
      .x2_i (in_a2),
      .x3_i (in_a3),
      .s_o  (s1),
      .c_o  (c1)
   );

   compr42_row #(.WIDTH(WIDTH)) u_lvl2 (
      .x0_i (s1),
      .x1_i (c1),
      .x2_i (acc_s_in),
      .x3_i (acc_c_in),
      .s_o  (s2),
      .c_o  (c2)
   );

   always_comb begin
      cnt_inc     = (acc_zero ? '0 : cnt_q) + CntW'(1);
      // A full group without a last flag is closed here rather than overflowing.
      force_last  = !in_last && (cnt_inc >= CntW'(MAX_BEATS));
      fire_last   = fire & (in_last | force_last);

      state_d     = state_q;
      acc_s_d     = acc_s_q;
      acc_c_d     = acc_c_q;
      cnt_d       = cnt_q;
      out_sum_d   = out_sum_q;
      out_carry_d = out_carry_q;
      out_valid_d = out_valid_q & !out_ready;
      err_d       = 1'b0;

      if (fire) begin
         err_d = force_last | (in_first & (state_q == ACC));
         if (fire_last) begin
            state_d     = IDLE;
            acc_s_d     = '0;
            acc_c_d     = '0;
            cnt_d       = '0;
            out_sum_d   = s2;
            out_carry_d = c2;
            out_valid_d = 1'b1;
         end else begin
            state_d = ACC;
            acc_s_d = s2;
            acc_c_d = c2;
            cnt_d   = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         acc_s_q     <= '0;
         acc_c_q     <= '0;
         cnt_q       <= '0;
         out_sum_q   <= '0;
         out_carry_q <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_s_q     <= acc_s_d;
         acc_c_q     <= acc_c_d;
         cnt_q       <= cnt_d;
         out_sum_q   <= out_sum_d;
         out_carry_q <= out_carry_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

`ifdef COMPR42_ACC_PIPE_CPA_EN
   logic [WIDTH-1:0] out_res_q, out_res_d;

   always_comb begin
      out_res_d = out_res_q;
      if (fire_last) out_res_d = s2 + c2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) out_res_q <= '0;
      else      out_res_q <= out_res_d;
   end

   assign out_res = out_res_q;
`else
   assign out_res = '0;
`endif

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_carry = out_carry_q;
   assign beat_cnt  = cnt_q;
   assign err       = err_q;

endmodule

// File: tb/tb_compr42_acc_pipe.sv
// Directed and random checks of compr42_acc_pipe against a scoreboard of expected group sums.
// A negedge monitor keeps a reference model of the accumulator, counter and error pulse.
module tb_compr42_acc_pipe;

   localparam int unsigned W  = 16;
   localparam int unsigned MB = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         in_first = 1'b0;
   logic         in_last = 1'b0;
   logic [W-1:0] in_a0 = '0, in_a1 = '0, in_a2 = '0, in_a3 = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_sum, out_carry, out_res;
   logic [3:0]   beat_cnt;
   logic         err;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] ref_acc = '0;
   int           ref_cnt = 0;
   bit           ref_active = 1'b0;
   logic         exp_err = 1'b0;

   always #5 clk = ~clk;

   compr42_acc_pipe #(.WIDTH(W), .MAX_BEATS(MB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_last   (in_last),
      .in_a0     (in_a0),
      .in_a1     (in_a1),
      .in_a2     (in_a2),
      .in_a3     (in_a3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_res   (out_res),
      .beat_cnt  (beat_cnt),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] sum16();
      return out_sum + out_carry;
   endfunction

   // Offer one beat and return just after the edge that accepts it.
   task automatic send(input logic f, input logic l, input logic [W-1:0] a0,
                       input logic [W-1:0] a1, input logic [W-1:0] a2, input logic [W-1:0] a3);
      bit ok;
      int n;
      in_first = f;
      in_last  = l;
      in_a0 = a0; in_a1 = a1; in_a2 = a2; in_a3 = a3;
      in_valid = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: observed=in_ready low for %0d cycles expected=accept", n);
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] base, tot, e;
      int           cnt;
      if (!rst) begin
         exp_q.delete();
         ref_acc    = '0;
         ref_cnt    = 0;
         ref_active = 1'b0;
         exp_err    = 1'b0;
      end else begin
         chk("mon_out_valid", out_valid, exp_q.size() != 0);
         chk("mon_in_ready", in_ready, (exp_q.size() == 0) || out_ready);
         chk("mon_beat_cnt", beat_cnt, ref_cnt);
         chk("mon_err", err, exp_err);
         if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("mon_result", sum16(), e);
`ifdef COMPR42_ACC_PIPE_CPA_EN
            chk("mon_out_res", out_res, e);
`else
            chk("mon_out_res", out_res, 0);
`endif
         end
         exp_err = 1'b0;
         if (in_valid && in_ready) begin
            base = (in_first || !ref_active) ? '0 : ref_acc;
            tot  = base + in_a0 + in_a1 + in_a2 + in_a3;
            cnt  = (in_first || !ref_active) ? 1 : ref_cnt + 1;
            exp_err = (in_first && ref_active) || (!in_last && cnt >= MB);
            if (in_last || cnt >= MB) begin
               exp_q.push_back(tot);
               ref_active = 1'b0;
               ref_cnt    = 0;
               ref_acc    = '0;
            end else begin
               ref_active = 1'b1;
               ref_cnt    = cnt;
               ref_acc    = tot;
            end
         end
      end
   end

   initial begin
      logic [W-1:0] hs, hc;

      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_carry", out_carry, 0);
      chk("rst_out_res", out_res, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Single beat.
      send(1'b1, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4);
      chk("t1_valid", out_valid, 1);
      chk("t1_sum", sum16(), 10);

      // Two-beat group.
      send(1'b1, 1'b0, 16'd100, 16'd200, 16'd300, 16'd400);
      chk("t2_cnt1", beat_cnt, 1);
      send(1'b0, 1'b1, 16'd1, 16'd1, 16'd1, 16'd1);
      chk("t2_sum", sum16(), 1004);
      chk("t2_cnt0", beat_cnt, 0);

      // Wrap-around.
      send(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      chk("t3_sum", sum16(), 16'hFFFC);
`ifdef COMPR42_ACC_PIPE_CPA_EN
      chk("t3_res", out_res, 16'hFFFC);
`endif

      // Backpressure with a pending beat, then pop and reload on the same edge.
      out_ready = 1'b0;
      hs = out_sum;
      hc = out_carry;
      in_first = 1'b1; in_last = 1'b1;
      in_a0 = 16'd9; in_a1 = 16'd9; in_a2 = '0; in_a3 = '0;
      in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("t4_in_ready", in_ready, 0);
         chk("t4_valid", out_valid, 1);
         chk("t4_sum_stable", out_sum, hs);
         chk("t4_carry_stable", out_carry, hc);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      chk("t4_reload_valid", out_valid, 1);
      chk("t4_reload_sum", sum16(), 18);

      // Restart inside a group, then an over-long group.
      send(1'b1, 1'b0, 16'd1, '0, '0, '0);
      send(1'b0, 1'b0, 16'd1, '0, '0, '0);
      send(1'b0, 1'b0, 16'd1, '0, '0, '0);
      chk("t5_cnt3", beat_cnt, 3);
      send(1'b1, 1'b1, 16'd5, '0, '0, '0);
      chk("t5_restart_err", err, 1);
      chk("t5_restart_sum", sum16(), 5);
      repeat (7) send(1'b0, 1'b0, 16'd1, '0, '0, '0);
      chk("t5_err_quiet", err, 0);
      chk("t5_cnt7", beat_cnt, 7);
      send(1'b0, 1'b0, 16'd1, '0, '0, '0);
      chk("t5_max_err", err, 1);
      chk("t5_max_valid", out_valid, 1);
      chk("t5_max_sum", sum16(), 8);
      chk("t5_max_cnt", beat_cnt, 0);

      // Asynchronous reset mid-group.
      send(1'b1, 1'b0, 16'd3, '0, '0, '0);
      send(1'b0, 1'b0, 16'd3, '0, '0, '0);
      #2 rst = 1'b0;
      #1;
      chk("t6_valid", out_valid, 0);
      chk("t6_sum", out_sum, 0);
      chk("t6_carry", out_carry, 0);
      chk("t6_res", out_res, 0);
      chk("t6_cnt", beat_cnt, 0);
      chk("t6_err", err, 0);
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      send(1'b1, 1'b1, 16'd2, 16'd2, 16'd2, 16'd2);
      chk("t6_after_sum", sum16(), 8);

      // Random traffic; the monitor scores every handshake.
      repeat (400) begin
         @(posedge clk);
         #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_first  = ($urandom_range(0, 7) == 0);
         in_last   = ($urandom_range(0, 3) == 0);
         in_a0     = W'($urandom);
         in_a1     = W'($urandom);
         in_a2     = W'($urandom);
         in_a3     = W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
